peripheral_input: RTL

PERIPHERAL_INPUT -- requirements
Module: peripheral_input

---
 rtl/peripheral_input.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/peripheral_input.sv
// ---------------------------------------------------------------------------
// peripheral_input
//
// Pushbutton-qualified switch sampler. A debounced press of key_n latches the
// switch bank and presents it to the processor. The value is held until the
// processor acknowledges it. After that, the key must be released and debounced
// before another press is accepted, so each physical press yields at most one
// value.
//
// Handshake: peripheral_signal is "valid" and peripheral_ack is "ready/taken".
// Once peripheral_signal rises, both it and peripheral_value stay frozen until
// a clock edge samples peripheral_ack=1. On that edge the transfer completes:
// peripheral_signal drops and accept_count advances by one (mod 256).
// peripheral_ack has no effect while peripheral_signal is low.
//
// Ports
//   clock              rising-edge system clock
//   reset              asynchronous, active-low reset
//   key_n              raw asynchronous pushbutton, low = pressed
//   switches           raw switch bank (WIDTH bits)
//   peripheral_ack     processor has consumed peripheral_value
//   peripheral_signal  peripheral_value is valid
//   peripheral_value   switch value latched at the debounced press
//   accept_count       completed handshakes, wraps 255 -> 0
//   dbg_state          current FSM state (IDLE=0, DEB_PRESS=1, PRESENT=2,
//                      WAIT_REL=3, DEB_REL=4)
// ---------------------------------------------------------------------------
module peripheral_input #(
  parameter int WIDTH           = 5,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             key_n,
  input  logic [WIDTH-1:0] switches,
  input  logic             peripheral_ack,
  output logic             peripheral_signal,
  output logic [WIDTH-1:0] peripheral_value,
  output logic [7:0]       accept_count,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DEB_PRESS = 3'd1,
    ST_PRESENT   = 3'd2,
    ST_WAIT_REL  = 3'd3,
    ST_DEB_REL   = 3'd4
  } state_t;

  localparam logic [15:0] DEB_MAX = 16'(DEBOUNCE_CYCLES);

  // Synchronizer flops reset to 1 (key released), so a key held low
  // across reset is seen as a fresh falling edge once reset is removed.
  logic             r_sync1;
  logic             r_sync2;
  logic             w_key_s;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [15:0]      r_cnt;
  logic [15:0]      w_cnt_nxt;
  logic             r_signal;
  logic             w_signal_nxt;
  logic [WIDTH-1:0] r_value;
  logic [WIDTH-1:0] w_value_nxt;
  logic [7:0]       r_accept;
  logic [7:0]       w_accept_nxt;

  assign w_key_s = r_sync2;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= key_n;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 16'd0;
      r_signal <= 1'b0;
      r_value  <= '0;
      r_accept <= 8'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_signal <= w_signal_nxt;
      r_value  <= w_value_nxt;
      r_accept <= w_accept_nxt;
    end
  end

  // The counter holds the number of consecutive qualifying key_s samples.
  // A state exits on the edge that sees the counter already at
  // DEBOUNCE_CYCLES with the key still qualifying. The counter never
  // increments past that value.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_signal_nxt = r_signal;
    w_value_nxt  = r_value;
    w_accept_nxt = r_accept;
    case (r_state)
      ST_IDLE: begin
        if (!w_key_s) begin
          w_state_nxt = ST_DEB_PRESS;
          w_cnt_nxt   = 16'd1;
        end else begin
          w_cnt_nxt   = 16'd0;
        end
      end
      ST_DEB_PRESS: begin
        if (w_key_s) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 16'd0;
        end else if (r_cnt >= DEB_MAX) begin
          w_state_nxt  = ST_PRESENT;
          w_cnt_nxt    = 16'd0;
          w_value_nxt  = switches;
          w_signal_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      ST_PRESENT: begin
        // Key activity is ignored here. A release that happens meanwhile
        // is picked up by WAIT_REL, because key_s is simply already high.
        if (peripheral_ack) begin
          w_state_nxt  = ST_WAIT_REL;
          w_signal_nxt = 1'b0;
          w_accept_nxt = r_accept + 8'd1;
        end
      end
      ST_WAIT_REL: begin
        if (w_key_s) begin
          w_state_nxt = ST_DEB_REL;
          w_cnt_nxt   = 16'd1;
        end else begin
          w_cnt_nxt   = 16'd0;
        end
      end
      ST_DEB_REL: begin
        if (!w_key_s) begin
          w_state_nxt = ST_WAIT_REL;
          w_cnt_nxt   = 16'd0;
        end else if (r_cnt >= DEB_MAX) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 16'd0;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      default: begin
        w_state_nxt  = ST_IDLE;
        w_cnt_nxt    = 16'd0;
        w_signal_nxt = 1'b0;
      end
    endcase
  end

  assign peripheral_signal = r_signal;
  assign peripheral_value  = r_value;
  assign accept_count      = r_accept;
  assign dbg_state         = r_state;

endmodule
